// File: rtl/switch_pkg.sv
// Shared types and the round-robin helper for the 4-to-1 merging switch.
package switch_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int DEF_DATA_W = 8;

   typedef logic [1:0] port_t;

   typedef struct packed {
      logic  vld;
      port_t idx;
   } grant_t;

   // Search starts one past the last winner and wraps; the last winner is checked last.
   function automatic grant_t rr_next(input logic [NUM_PORTS-1:0] req, input port_t last);
      grant_t g;
      port_t  c;
      g = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         c = last + port_t'(i);
         if (!g.vld && req[c]) begin
            g.vld = 1'b1;
            g.idx = c;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Per-port input FIFO: registered full/drop flags, no write-to-read bypass.
module switch_port_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic              drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d, drop_q, drop_d;
   logic              wr_ok, pop;

   always_comb begin
      pop      = rd_en && (count_q != '0);
      // A pop in the same cycle frees the slot a full FIFO needs for this write.
      wr_ok    = wr_en && (!full_q || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(DEPTH));
      drop_d = wr_en && !wr_ok;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign full    = full_q;
   assign drop    = drop_q;

endmodule

// File: rtl/switch_merge_4to1.sv
// Four input FIFOs drained round-robin onto one registered, port-tagged output.
module switch_merge_4to1
   import switch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready_in_0,
   input  logic              ready_in_1,
   input  logic              ready_in_2,
   input  logic              ready_in_3,
   input  logic [DATA_W-1:0] data_in_0,
   input  logic [DATA_W-1:0] data_in_1,
   input  logic [DATA_W-1:0] data_in_2,
   input  logic [DATA_W-1:0] data_in_3,
   output logic              full_0,
   output logic              full_1,
   output logic              full_2,
   output logic              full_3,
   output logic              drop_0,
   output logic              drop_1,
   output logic              drop_2,
   output logic              drop_3,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        port_num
);

   logic [NUM_PORTS-1:0]             wr_en, rd_en, empty_v, full_v, drop_v;
   logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data, rd_data;
   grant_t                           gnt;
   port_t                            last_grant_q, last_grant_d;
   logic                             ready_out_q, ready_out_d;
   logic [DATA_W-1:0]                data_out_q, data_out_d;
   port_t                            port_num_q, port_num_d;

   assign wr_en   = {ready_in_3, ready_in_2, ready_in_1, ready_in_0};
   assign wr_data = {data_in_3, data_in_2, data_in_1, data_in_0};

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      switch_port_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[i]),
         .wr_data (wr_data[i]),
         .rd_en   (rd_en[i]),
         .rd_data (rd_data[i]),
         .empty   (empty_v[i]),
         .full    (full_v[i]),
         .drop    (drop_v[i])
      );
   end

   always_comb begin
      gnt          = rr_next(~empty_v, last_grant_q);
      rd_en        = '0;
      last_grant_d = last_grant_q;
      ready_out_d  = gnt.vld;
      data_out_d   = '0;
      port_num_d   = '0;
      if (gnt.vld) begin
         rd_en[gnt.idx] = 1'b1;
         last_grant_d   = gnt.idx;
         data_out_d     = rd_data[gnt.idx];
         port_num_d     = gnt.idx;
      end
   end

   // last_grant resets to 3 so the first search starts at port 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 2'd3;
         ready_out_q  <= 1'b0;
         data_out_q   <= '0;
         port_num_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         ready_out_q  <= ready_out_d;
         data_out_q   <= data_out_d;
         port_num_q   <= port_num_d;
      end
   end

   assign {full_3, full_2, full_1, full_0} = full_v;
   assign {drop_3, drop_2, drop_1, drop_0} = drop_v;
   assign ready_out = ready_out_q;
   assign data_out  = data_out_q;
   assign port_num  = port_num_q;

   a_idle_zero: assert property (@(posedge clk) disable iff (reset)
      !ready_out |-> (data_out == '0 && port_num == '0));
   a_one_pop: assert property (@(posedge clk) disable iff (reset) $onehot0(rd_en));
   a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
      (rd_en & empty_v) == '0);

endmodule

// File: tb/tb_switch_merge_4to1.sv
// Directed bench: queue-based model checked every cycle, plus literal test-plan checks.
module tb_switch_merge_4to1;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rin;
   logic [7:0] din [4];
   logic       f0, f1, f2, f3, d0, d1, d2, d3;
   logic       ready_out;
   logic [7:0] data_out;
   logic [1:0] port_num;
   logic [3:0] full_v, drop_v;

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

   switch_merge_4to1 #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .ready_in_0(rin[0]), .ready_in_1(rin[1]), .ready_in_2(rin[2]), .ready_in_3(rin[3]),
      .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
      .full_0(f0), .full_1(f1), .full_2(f2), .full_3(f3),
      .drop_0(d0), .drop_1(d1), .drop_2(d2), .drop_3(d3),
      .ready_out(ready_out), .data_out(data_out), .port_num(port_num)
   );

   assign full_v = {f3, f2, f1, f0};
   assign drop_v = {d3, d2, d1, d0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one queue per port, pop-first-then-push each edge.
   logic [7:0] mq [4][$];
   int         m_last = 3;
   int         mg, mc;
   logic       m_rdy = 1'b0;
   logic [7:0] m_data = '0;
   logic [1:0] m_port = '0;
   logic [3:0] m_full = '0, m_drop = '0;

   always @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 4; p++) mq[p].delete();
         m_last = 3;
         m_rdy  = 1'b0;
         m_data = '0;
         m_port = '0;
         m_full = '0;
         m_drop = '0;
      end else begin
         mg = -1;
         for (int k = 1; k <= 4; k++) begin
            mc = (m_last + k) % 4;
            if (mg < 0 && mq[mc].size() > 0) mg = mc;
         end
         if (mg >= 0) begin
            m_rdy  = 1'b1;
            m_data = mq[mg].pop_front();
            m_port = 2'(mg);
            m_last = mg;
         end else begin
            m_rdy  = 1'b0;
            m_data = '0;
            m_port = '0;
         end
         for (int p = 0; p < 4; p++) begin
            m_drop[p] = 1'b0;
            if (rin[p]) begin
               if (mq[p].size() < DEPTH) mq[p].push_back(din[p]);
               else m_drop[p] = 1'b1;
            end
            m_full[p] = (mq[p].size() == DEPTH);
         end
      end
   end

   logic       cmp_en = 1'b0;
   int         out_cnt = 0, drop_cnt = 0, full_seen = 0;
   logic [7:0] p3_log [$];

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready_out", 32'(ready_out), 32'(m_rdy));
         chk("data_out", 32'(data_out), 32'(m_data));
         chk("port_num", 32'(port_num), 32'(m_port));
         chk("full", 32'(full_v), 32'(m_full));
         chk("drop", 32'(drop_v), 32'(m_drop));
         if (ready_out) out_cnt++;
         drop_cnt += $countones(drop_v);
         if (full_v != '0) full_seen++;
         if (ready_out && port_num == 2'd3) p3_log.push_back(data_out);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rin   = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic r, input logic [7:0] d, input logic [1:0] p);
      chk({name, "_rdy"}, 32'(ready_out), 32'(r));
      chk({name, "_data"}, 32'(data_out), 32'(d));
      chk({name, "_port"}, 32'(port_num), 32'(p));
   endtask

   int base_out, base_drop, base_p3;

   initial begin
      reset = 1'b1;
      rin   = '0;
      for (int p = 0; p < 4; p++) din[p] = '0;
      tick();
      tick();
      cmp_en = 1'b1;
      chk_out("reset", 1'b0, 8'h00, 2'd0);
      chk("reset_full", 32'(full_v), 32'h0);
      chk("reset_drop", 32'(drop_v), 32'h0);
      reset = 1'b0;

      // Single byte on port 2
      rin[2] = 1'b1; din[2] = 8'hA5;
      tick();
      rin = '0;
      chk_out("single_wr", 1'b0, 8'h00, 2'd0);
      tick();
      chk_out("single", 1'b1, 8'hA5, 2'd2);
      tick();
      chk_out("single_after", 1'b0, 8'h00, 2'd0);

      // Fairness after reset
      do_reset();
      rin = 4'hF;
      for (int p = 0; p < 4; p++) din[p] = 8'h10 + 8'(p);
      tick();
      rin = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out("fair", 1'b1, 8'h10 + 8'(k), 2'(k));
      end
      tick();
      chk_out("fair_idle", 1'b0, 8'h00, 2'd0);

      // Round-robin continuation
      do_reset();
      rin = 4'b0010; din[1] = 8'h21;
      tick();
      rin = 4'b0111; din[0] = 8'h01; din[1] = 8'h22; din[2] = 8'h31;
      tick();
      rin = '0;
      chk_out("rr_b", 1'b1, 8'h21, 2'd1);
      tick();
      chk_out("rr_c", 1'b1, 8'h31, 2'd2);
      tick();
      chk_out("rr_d", 1'b1, 8'h01, 2'd0);
      tick();
      chk_out("rr_e", 1'b1, 8'h22, 2'd1);
      tick();

      // Overflow: all ports write 0..7 for eight cycles
      do_reset();
      base_out  = out_cnt;
      base_drop = drop_cnt;
      full_seen = full_seen;
      for (int c = 0; c < 8; c++) begin
         rin = 4'hF;
         for (int p = 0; p < 4; p++) din[p] = 8'(c);
         tick();
      end
      rin = '0;
      repeat (20) tick();
      chk("ovf_total", 32'((out_cnt - base_out) + (drop_cnt - base_drop)), 32'd32);
      chk("ovf_dropped", 32'((drop_cnt - base_drop) > 0), 32'd1);
      chk("ovf_full_seen", 32'(full_seen > 0), 32'd1);

      // Full FIFO accepts a write in the cycle it is popped
      do_reset();
      base_p3 = p3_log.size();
      for (int c = 0; c < 4; c++) begin
         rin = 4'hF;
         for (int p = 0; p < 4; p++) din[p] = 8'h30 + 8'(c);
         tick();
      end
      chk("fp_full3", 32'(f3), 32'd1);
      rin = 4'b1000; din[3] = 8'hEE;
      tick();
      rin = '0;
      chk("fp_nodrop3", 32'(d3), 32'd0);
      chk("fp_full3_hold", 32'(f3), 32'd1);
      chk_out("fp_pop3", 1'b1, 8'h30, 2'd3);
      repeat (16) tick();
      chk("fp_p3_count", 32'(p3_log.size() - base_p3), 32'd5);
      chk("fp_p3_last", 32'(p3_log[p3_log.size()-1]), 32'hEE);

      // Reset mid-operation
      rin = 4'b0111; din[0] = 8'h40; din[1] = 8'h41; din[2] = 8'h42;
      tick();
      din[0] = 8'h43; din[1] = 8'h44; din[2] = 8'h45;
      tick();
      reset = 1'b1;
      tick();
      chk_out("mid_rst", 1'b0, 8'h00, 2'd0);
      chk("mid_rst_full", 32'(full_v), 32'h0);
      chk("mid_rst_drop", 32'(drop_v), 32'h0);
      reset = 1'b0;
      rin   = '0;
      base_out = out_cnt;
      repeat (3) tick();
      chk("mid_rst_stale", 32'(out_cnt - base_out), 32'd0);
      rin[1] = 1'b1; din[1] = 8'h55;
      tick();
      rin = '0;
      tick();
      chk_out("post_rst", 1'b1, 8'h55, 2'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
